// File: rtl/accel_pkg.sv
// Shared accelerator types: operand/result shapes, operation codes and the
// compute-arbiter state encoding.
package accel_pkg;

  localparam int UNIT_COUNT    = 8;
  localparam int UNIT_ID_WIDTH = $clog2(UNIT_COUNT);

  localparam int ELEM_WIDTH = 8;
  localparam int VECTOR_LEN = 4;

  typedef logic [VECTOR_LEN-1:0][ELEM_WIDTH-1:0] vector_t;
  typedef vector_t [VECTOR_LEN-1:0]              matrix_t;

  typedef enum logic [1:0] {
    COMP_DOT    = 2'd0,
    COMP_ADD    = 2'd1,
    COMP_MUL    = 2'd2,
    COMP_MATVEC = 2'd3
  } comp_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEFAULT = 255;
  localparam int ARB_WDOG_WIDTH      = 16;

  // One-hot vector with only bit `id` set.
  function automatic logic [UNIT_COUNT-1:0] unit_onehot(input logic [UNIT_ID_WIDTH-1:0] id);
    return UNIT_COUNT'(1) << id;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first asserted request
// searching upward from the slot after the previous grant, with wrap-around.
module rr_priority_picker
  import accel_pkg::*;
(
  input  logic [UNIT_COUNT-1:0]    i_req,
  input  logic [UNIT_ID_WIDTH-1:0] i_last_id,
  output logic [UNIT_COUNT-1:0]    o_gnt,
  output logic [UNIT_ID_WIDTH-1:0] o_id,
  output logic                     o_valid
);

  // Rotating priority search; the slot right after the last grant wins ties.
  always_comb begin
    int                       slot;
    logic [UNIT_ID_WIDTH-1:0] slot_id;
    logic                     found;
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    o_gnt   = '0;
    o_id    = '0;
    o_valid = 1'b0;
    found   = 1'b0;
    slot    = 0;
    slot_id = '0;
    for (int i = 1; i <= UNIT_COUNT; i++) begin
      slot = int'(i_last_id) + i;
      if (slot >= UNIT_COUNT) begin
        slot = slot - UNIT_COUNT;
      end
      slot_id = UNIT_ID_WIDTH'(slot);
      if (!found && i_req[slot_id]) begin
        found   = 1'b1;
        o_valid = 1'b1;
        o_id    = slot_id;
        o_gnt   = unit_onehot(slot_id);
      end
    end
  end

endmodule

// File: rtl/compute_arbiter.sv
// Round-robin arbiter and sequencer sharing one compute unit among the
// processing units: grants a requester, latches its operands, runs the
// request/ready/done handshake under a watchdog and returns the result.
module compute_arbiter
  import accel_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arb_enable,
  input  logic [UNIT_COUNT-1:0]    req,
  input  comp_type_e               req_comp_type [UNIT_COUNT],
  input  vector_t                  req_vector_a  [UNIT_COUNT],
  input  vector_t                  req_vector_b  [UNIT_COUNT],
  input  matrix_t                  req_matrix    [UNIT_COUNT],
  output logic [UNIT_COUNT-1:0]    gnt,
  output logic [UNIT_COUNT-1:0]    rsp_valid,
  output logic                     rsp_err,
  output vector_t                  rsp_data,
  output logic                     cu_request,
  input  logic                     cu_ready,
  input  logic                     cu_done,
  output logic [UNIT_ID_WIDTH-1:0] cu_unit_id,
  output comp_type_e               cu_comp_type,
  output vector_t                  cu_vector_a,
  output vector_t                  cu_vector_b,
  output matrix_t                  cu_matrix,
  input  vector_t                  cu_result,
  output logic                     busy,
  output logic [UNIT_ID_WIDTH-1:0] active_id,
  output logic [15:0]              op_count,
  output logic                     timeout_sticky
);

  // The watchdog fires in the cycle that would complete TIMEOUT_CYCLES
  // cycles spent in ISSUE+WAIT.
  localparam logic [ARB_WDOG_WIDTH-1:0] WDOG_LAST = ARB_WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_e                r_state;
  arb_state_e                w_next_state;
  logic [UNIT_ID_WIDTH-1:0]  r_id;
  logic [UNIT_ID_WIDTH-1:0]  r_last_id;
  comp_type_e                r_comp_type;
  vector_t                   r_vector_a;
  vector_t                   r_vector_b;
  matrix_t                   r_matrix;
  logic [UNIT_COUNT-1:0]     r_gnt;
  logic                      r_rsp_err;
  vector_t                   r_rsp_data;
  logic [ARB_WDOG_WIDTH-1:0] r_wdog;
  logic [15:0]               r_op_count;
  logic                      r_timeout_sticky;

  logic [UNIT_COUNT-1:0]     w_pick_gnt;
  logic [UNIT_ID_WIDTH-1:0]  w_pick_id;
  logic                      w_pick_valid;
  logic                      w_take_grant;
  logic                      w_op_done;
  logic                      w_op_timeout;

  rr_priority_picker u_picker (
    .i_req     (req),
    .i_last_id (r_last_id),
    .o_gnt     (w_pick_gnt),
    .o_id      (w_pick_id),
    .o_valid   (w_pick_valid)
  );

  // Next-state decode plus the grant/completion/timeout events of this cycle.
  always_comb begin
    w_next_state = r_state;
    w_take_grant = 1'b0;
    w_op_done    = 1'b0;
    w_op_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (arb_enable && w_pick_valid) begin
          w_take_grant = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_wdog == WDOG_LAST) begin
          w_op_timeout = 1'b1;
          w_next_state = RESP;
        end else if (cu_ready) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        // A result arriving in the timeout cycle still counts as success.
        if (cu_done) begin
          w_op_done    = 1'b1;
          w_next_state = RESP;
        end else if (r_wdog == WDOG_LAST) begin
          w_op_timeout = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register, operand latch, watchdog, response capture and counters.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // updates from values sampled at the same edge, independent of order.
    if (rst) begin
      r_state          <= IDLE;
      r_id             <= '0;
      r_last_id        <= UNIT_ID_WIDTH'(UNIT_COUNT - 1);
      r_comp_type      <= COMP_DOT;
      r_vector_a       <= '0;
      r_vector_b       <= '0;
      r_matrix         <= '0;
      r_gnt            <= '0;
      r_rsp_err        <= 1'b0;
      r_rsp_data       <= '0;
      r_wdog           <= '0;
      r_op_count       <= '0;
      r_timeout_sticky <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= '0;

      if (w_take_grant) begin
        r_id        <= w_pick_id;
        r_comp_type <= req_comp_type[w_pick_id];
        r_vector_a  <= req_vector_a[w_pick_id];
        r_vector_b  <= req_vector_b[w_pick_id];
        r_matrix    <= req_matrix[w_pick_id];
        r_gnt       <= w_pick_gnt;
        r_wdog      <= '0;
      end

      if (r_state == ISSUE || r_state == WAIT) begin
        r_wdog <= r_wdog + ARB_WDOG_WIDTH'(1);
      end

      if (w_op_done) begin
        r_rsp_data <= cu_result;
        r_rsp_err  <= 1'b0;
      end

      if (w_op_timeout) begin
        r_rsp_data       <= '0;
        r_rsp_err        <= 1'b1;
        r_timeout_sticky <= 1'b1;
      end

      if (r_state == RESP) begin
        r_op_count <= r_op_count + 16'd1;
        r_last_id  <= r_id;
      end
    end
  end

  assign gnt            = r_gnt;
  assign rsp_valid      = (r_state == RESP) ? unit_onehot(r_id) : '0;
  assign rsp_err        = r_rsp_err;
  assign rsp_data       = r_rsp_data;
  assign cu_request     = (r_state == ISSUE);
  assign cu_unit_id     = r_id;
  assign cu_comp_type   = r_comp_type;
  assign cu_vector_a    = r_vector_a;
  assign cu_vector_b    = r_vector_b;
  assign cu_matrix      = r_matrix;
  assign busy           = (r_state != IDLE);
  assign active_id      = r_id;
  assign op_count       = r_op_count;
  assign timeout_sticky = r_timeout_sticky;

endmodule

// File: tb/tb_compute_arbiter.sv
// Directed bench for compute_arbiter: a compute-unit responder answers the
// handshake, stimulus pushes expected responses into a queue and a monitor
// pops and compares them whenever rsp_valid is seen.
module tb_compute_arbiter;
  import accel_pkg::*;

  localparam int TB_TIMEOUT = 16;
  localparam int BUDGET     = 80;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     arb_enable;
  logic [UNIT_COUNT-1:0]    req;
  comp_type_e               req_comp_type [UNIT_COUNT];
  vector_t                  req_vector_a  [UNIT_COUNT];
  vector_t                  req_vector_b  [UNIT_COUNT];
  matrix_t                  req_matrix    [UNIT_COUNT];
  logic [UNIT_COUNT-1:0]    gnt;
  logic [UNIT_COUNT-1:0]    rsp_valid;
  logic                     rsp_err;
  vector_t                  rsp_data;
  logic                     cu_request;
  logic                     cu_ready;
  logic                     cu_done;
  logic [UNIT_ID_WIDTH-1:0] cu_unit_id;
  comp_type_e               cu_comp_type;
  vector_t                  cu_vector_a;
  vector_t                  cu_vector_b;
  matrix_t                  cu_matrix;
  vector_t                  cu_result;
  logic                     busy;
  logic [UNIT_ID_WIDTH-1:0] active_id;
  logic [15:0]              op_count;
  logic                     timeout_sticky;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rsp_cyc = -1;

  // Responder behaviour knobs and its private state.
  int ready_wait = 0;
  int done_wait  = 0;
  bit done_en    = 1'b1;
  int cu_req_cnt;
  int cu_wait_cnt;
  bit cu_in_wait;

  typedef struct {
    int      id;
    logic    err;
    vector_t data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  compute_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .arb_enable     (arb_enable),
    .req            (req),
    .req_comp_type  (req_comp_type),
    .req_vector_a   (req_vector_a),
    .req_vector_b   (req_vector_b),
    .req_matrix     (req_matrix),
    .gnt            (gnt),
    .rsp_valid      (rsp_valid),
    .rsp_err        (rsp_err),
    .rsp_data       (rsp_data),
    .cu_request     (cu_request),
    .cu_ready       (cu_ready),
    .cu_done        (cu_done),
    .cu_unit_id     (cu_unit_id),
    .cu_comp_type   (cu_comp_type),
    .cu_vector_a    (cu_vector_a),
    .cu_vector_b    (cu_vector_b),
    .cu_matrix      (cu_matrix),
    .cu_result      (cu_result),
    .busy           (busy),
    .active_id      (active_id),
    .op_count       (op_count),
    .timeout_sticky (timeout_sticky)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [UNIT_COUNT-1:0] bit_of(input int u);
    return UNIT_COUNT'(1) << u;
  endfunction

  // Compute-unit behaviour: result is a fixed mix of the operands it was given.
  function automatic vector_t model_result(input int u);
    return req_vector_a[u] ^ req_vector_b[u] ^ req_matrix[u][0]
         ^ vector_t'({req_comp_type[u], UNIT_ID_WIDTH'(u)});
  endfunction

  task automatic push_exp(input int id, input logic err, input vector_t data);
    exp_t e;
    e.id   = id;
    e.err  = err;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input int id, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = -1;
    for (int k = 0; k < BUDGET && !seen; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        seen   = 1'b1;
        at_cyc = cyc;
        check($sformatf("gnt_unit%0d", id), gnt, bit_of(id));
      end
    end
    if (!seen) check($sformatf("gnt_unit%0d_missing", id), 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < BUDGET && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) check("wait_idle_expired", 1'b0, 1'b1);
  endtask

  // Compute-unit responder: ready after ready_wait request cycles, done
  // done_wait cycles into WAIT (never when done_en is low).
  initial begin
    cu_ready    = 1'b0;
    cu_done     = 1'b0;
    cu_result   = '0;
    cu_req_cnt  = 0;
    cu_wait_cnt = 0;
    cu_in_wait  = 1'b0;
    forever begin
      @(negedge clk);
      cu_done = 1'b0;
      if (rst) begin
        cu_ready   = 1'b0;
        cu_in_wait = 1'b0;
        cu_req_cnt = 0;
      end else begin
        if (cu_in_wait) begin
          if (done_en && cu_wait_cnt == done_wait) begin
            cu_done    = 1'b1;
            cu_result  = cu_vector_a ^ cu_vector_b ^ cu_matrix[0]
                       ^ vector_t'({cu_comp_type, cu_unit_id});
            cu_in_wait = 1'b0;
          end
          cu_wait_cnt++;
        end
        if (cu_request) begin
          if (cu_req_cnt >= ready_wait) begin
            cu_ready    = 1'b1;
            cu_in_wait  = 1'b1;
            cu_wait_cnt = 0;
            cu_req_cnt  = 0;
          end else begin
            cu_ready = 1'b0;
            cu_req_cnt++;
          end
        end else begin
          cu_ready   = 1'b0;
          cu_req_cnt = 0;
        end
      end
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (!rst && rsp_valid != '0) begin
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("rsp_valid_unit%0d", mon_e.id), rsp_valid, bit_of(mon_e.id));
        check($sformatf("rsp_err_unit%0d", mon_e.id), rsp_err, mon_e.err);
        check($sformatf("rsp_data_unit%0d", mon_e.id), rsp_data, mon_e.data);
      end
    end
  end

  initial begin
    int      g;
    int      c;
    int      prev;
    int      n;
    bit      flag;
    vector_t saved_a;
    matrix_t saved_m;

    rst        = 1'b1;
    arb_enable = 1'b1;
    req        = '0;
    for (int u = 0; u < UNIT_COUNT; u++) begin
      req_comp_type[u] = comp_type_e'(u % 4);
      req_vector_a[u]  = vector_t'(32'h0101_0101 * (u + 1));
      req_vector_b[u]  = vector_t'(32'hA5C3_0000 + 32'(u * 17));
      req_matrix[u]    = matrix_t'({4{32'h5A5A_0F0F ^ 32'(u << 8)}});
    end
    tick(3);

    // Reset state
    check("reset_busy", busy, 0);
    check("reset_gnt", gnt, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_cu_request", cu_request, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_cu_vector_a", cu_vector_a, 0);
    check("reset_cu_matrix", cu_matrix, 0);
    check("reset_active_id", active_id, 0);
    check("reset_op_count", op_count, 0);
    check("reset_sticky", timeout_sticky, 0);
    rst = 1'b0;
    tick(1);

    // Single request from unit 2, done three cycles after ready
    done_wait = 2;
    c = cyc;
    req = 8'b0000_0100;
    push_exp(2, 1'b0, model_result(2));
    wait_gnt(2, g);
    check("single_gnt_latency", g, c + 1);
    check("single_cu_request", cu_request, 1);
    check("single_cu_unit_id", cu_unit_id, 2);
    req = '0;
    saved_a = req_vector_a[2];
    req_vector_a[2] = ~saved_a;
    wait_idle();
    req_vector_a[2] = saved_a;
    check("single_rsp_cycle", last_rsp_cyc, g + 4);
    check("single_op_count", op_count, 1);
    check("single_active_id", active_id, 2);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_op_count_clear", op_count, 0);

    // Fairness: all requesters held, immediate ready/done
    done_wait = 0;
    for (int k = 0; k < 9; k++) push_exp(k % 8, 1'b0, model_result(k % 8));
    c = cyc;
    req = '1;
    prev = 0;
    for (int k = 0; k < 9; k++) begin
      wait_gnt(k % 8, g);
      if (k == 0) check("fair_first_latency", g, c + 1);
      else        check($sformatf("fair_spacing_%0d", k), g - prev, 4);
      prev = g;
      if (k == 8) req = '0;
    end
    wait_idle();
    check("fair_op_count", op_count, 9);

    // Backpressure: ready withheld for 10 request cycles
    ready_wait = 10;
    done_wait  = 1;
    push_exp(5, 1'b0, model_result(5));
    saved_a = req_vector_a[5];
    saved_m = req_matrix[5];
    req = bit_of(5);
    wait_gnt(5, g);
    req = '0;
    req_vector_a[5] = '0;
    req_matrix[5]   = ~saved_m;
    n = 0;
    flag = 1'b1;
    while (cu_request && n < BUDGET) begin
      if (cu_vector_a !== saved_a || cu_matrix !== saved_m) flag = 1'b0;
      n++;
      @(negedge clk);
    end
    check("bp_request_cycles", n, 11);
    check("bp_operands_stable", flag, 1);
    req_vector_a[5] = saved_a;
    req_matrix[5]   = saved_m;
    wait_idle();

    // Timeout: no done ever
    ready_wait = 0;
    done_en    = 1'b0;
    push_exp(6, 1'b1, '0);
    req = bit_of(6);
    wait_gnt(6, g);
    req = '0;
    wait_idle();
    check("to_rsp_cycle", last_rsp_cyc, g + 16);
    check("to_sticky", timeout_sticky, 1);
    check("to_op_count", op_count, 11);

    // Next request after a timeout is served normally
    done_en   = 1'b1;
    done_wait = 0;
    push_exp(1, 1'b0, model_result(1));
    req = bit_of(1);
    wait_gnt(1, g);
    req = '0;
    wait_idle();
    check("to_next_rsp_cycle", last_rsp_cyc, g + 2);
    check("to_sticky_held", timeout_sticky, 1);

    // Done coincident with the timeout cycle is a success
    done_wait = 14;
    push_exp(4, 1'b0, model_result(4));
    req = bit_of(4);
    wait_gnt(4, g);
    req = '0;
    wait_idle();
    check("coinc_rsp_cycle", last_rsp_cyc, g + 16);

    // Enable low blocks grants until it rises
    done_wait  = 0;
    arb_enable = 1'b0;
    push_exp(3, 1'b0, model_result(3));
    req = bit_of(3);
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (gnt != '0) flag = 1'b1;
    end
    check("en_no_gnt", flag, 0);
    check("en_not_busy", busy, 0);
    c = cyc;
    arb_enable = 1'b1;
    wait_gnt(3, g);
    check("en_gnt_latency", g, c + 1);
    req = '0;
    wait_idle();
    check("en_op_count", op_count, 14);

    // Reset while waiting for a result
    done_en = 1'b0;
    req = bit_of(6);
    wait_gnt(6, g);
    req = '0;
    tick(3);
    check("mid_busy_before", busy, 1);
    check("mid_cu_request_wait", cu_request, 0);
    req = bit_of(1) | bit_of(5);
    tick(2);
    done_en   = 1'b1;
    done_wait = 0;
    push_exp(1, 1'b0, model_result(1));
    push_exp(5, 1'b0, model_result(5));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    c = cyc;
    check("mid_busy_after_rst", busy, 0);
    check("mid_cu_request_after_rst", cu_request, 0);
    check("mid_op_count_clear", op_count, 0);
    check("mid_sticky_clear", timeout_sticky, 0);
    wait_gnt(1, g);
    check("mid_first_gnt_latency", g, c + 1);
    req = bit_of(5);
    prev = g;
    wait_gnt(5, g);
    check("mid_second_gnt_spacing", g - prev, 4);
    req = '0;
    wait_idle();
    tick(2);
    check("mid_op_count", op_count, 2);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compute_arbiter.md
# compute_arbiter

Round-robin arbiter and sequencer that shares the single `shared_compute_unit` among the `UNIT_COUNT` processing units. It sits between the processing-unit array and the shared compute unit, replacing the fixed unit-0 mux in the accelerator top level. It grants one requester at a time and latches that requester's operands. It drives the compute unit's request/ready/done handshake, with a watchdog, and returns the result to the granted unit.

## Interface
- `UNIT_COUNT`, package value (8): number of requesters.
- `UNIT_ID_WIDTH`, package value (3): width of unit ID, `$clog2(UNIT_COUNT)`.
- `TIMEOUT_CYCLES`, 255: watchdog limit for one operation in ISSUE+WAIT, 1..65535.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `arb_enable`  in  1  from system controller; low blocks new grants, in-flight op completes.
- `req`  in  UNIT_COUNT  per-unit compute request; level, held until `gnt`.
- `req_comp_type`  in  comp_type_e[UNIT_COUNT]  operation per unit.
- `req_vector_a`, `req_vector_b`  in  vector_t[UNIT_COUNT]  operands per unit.
- `req_matrix`  in  matrix_t[UNIT_COUNT]  matrix operand per unit.
- `gnt`  out  UNIT_COUNT  one-hot, one-cycle grant pulse.
- `rsp_valid`  out  UNIT_COUNT  one-hot, one-cycle result-valid pulse.
- `rsp_err`  out  1  qualifies `rsp_valid`: op timed out.
- `rsp_data`  out  vector_t  result, broadcast to all units.
- `cu_request`  out  1  to `shared_compute_unit.request`.
- `cu_ready`  in  1  compute unit accepts request.
- `cu_done`  in  1  compute unit result valid.
- `cu_unit_id`, `cu_comp_type`, `cu_vector_a`, `cu_vector_b`, `cu_matrix`  out  operand bus, latched copy.
- `cu_result`  in  vector_t  compute unit result.
- `busy`  out  1  state != IDLE.
- `active_id`  out  UNIT_ID_WIDTH  ID of current or last grant.
- `op_count`  out  16  completed ops, including timeouts; wraps at 65535→0.
- `timeout_sticky`  out  1  set on any timeout, cleared only by `rst`.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If `arb_enable` and `|req`, choose the first set `req` searching upward from `last_id+1` modulo UNIT_COUNT.
  - Latch the ID and that unit's operands into registers, pulse `gnt[id]`, and go to ISSUE.
- ISSUE:
  - `cu_request`=1 with latched operands.
  - Handshake completes when `cu_request & cu_ready` in the same cycle; then go to WAIT.
- WAIT:
  - `cu_request`=0.
  - On `cu_done`, capture `cu_result` into `rsp_data`, `rsp_err`=0, and go to RESP.
  - `cu_done` is ignored outside WAIT.
- Watchdog:
  - Counter clears on entry to ISSUE and increments every ISSUE/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, go to RESP with `rsp_err`=1 and `rsp_data`=0, and set `timeout_sticky`.
  - `cu_done` in the same cycle as the timeout wins: the op is not an error.
- RESP:
  - `rsp_valid[id]`=1 for one cycle, `op_count`+1, `last_id`←id; go to IDLE.
- Operands are held in registers, so a requester's inputs may change after `gnt`.
- A requester still holding `req` after RESP is re-arbitrated normally.
- `arb_enable` is sampled only in IDLE.

## Timing
- Reset values:
  - FSM=IDLE; `gnt`, `rsp_valid`, `cu_request`=0; `rsp_err`=0; `rsp_data`=0.
  - Operand registers=0; `active_id`=0; `op_count`=0; `timeout_sticky`=0; `busy`=0.
  - `last_id`=UNIT_COUNT-1, so unit 0 has first priority.
- All outputs are registered or decoded from FSM state; no combinational path from `req` to `gnt`.
- Minimum latency: `req` sampled at edge N → `gnt` and `cu_request` high in cycle N+1.
  - `cu_ready` high in N+1 → WAIT in N+2.
  - `cu_done` in N+2 → `rsp_valid` in N+3.
  - IDLE in N+4, and the next grant is possible in N+5.
- `rst` mid-operation aborts immediately: no `rsp_valid`, `cu_request` drops next cycle. The compute unit is reset by the same `rst`.

## Structure
- `accel_pkg` already holds `vector_t`, `matrix_t`, `comp_type_e`, `UNIT_COUNT`, and `UNIT_ID_WIDTH`.
- Add to `accel_pkg`:
  - `arb_state_e`: IDLE/ISSUE/WAIT/RESP.
  - `ARB_TIMEOUT_DEFAULT`=255.
- One sub-module: `rr_priority_picker`, purely combinational. Inputs: `req` vector, `last_id`. Outputs: one-hot grant, ID, valid.
- The top level instantiates `compute_arbiter` between `gen_processing_units` and `u_shared_compute`.

## Test plan
- Single request: `req`=8'b0000_0100, `cu_ready`=1 immediately, `cu_done` 3 cycles later with `cu_result`=X → `gnt[2]` pulse, `cu_unit_id`=2, `rsp_valid[2]` with `rsp_data`=X, `op_count`=1.
- Fairness: all 8 `req` held high, ready/done immediate → grants in order 0,1,…,7,0, each exactly 4 cycles apart.
- Backpressure: `cu_ready` low 10 cycles → `cu_request` held 11 cycles with operands stable; then normal completion, `rsp_err`=0.
- Timeout: TIMEOUT_CYCLES=16, `cu_done` never → `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 16 cycles after ISSUE entry; `timeout_sticky`=1; the next request is still served.
- Boundary and enable cases:
  - `cu_done` coincident with the timeout cycle → `rsp_err`=0.
  - `arb_enable` low with `req` pending → no `gnt` until enable rises.
- Reset mid-WAIT: `rst` pulse → next cycle `busy`=0, no `rsp_valid` ever issued for the aborted op, and the first grant after reset goes to the lowest requesting ID.
